// File: rtl/seven_seg_mux.sv
// -----------------------------------------------------------------------------
// seven_seg_mux
//   Time-multiplexed driver for an NDIG-digit common-segment seven-segment
//   display. Each enabled digit gets one slot of CLK_DIV cycles. The first
//   BLANK cycles of every slot are dark, which suppresses ghosting while the
//   digit drivers switch over. Disabled digits are skipped. A one-cycle tick
//   marks each wrap back to the lowest enabled digit.
//
// Parameters
//   NDIG     number of digits (2..8)
//   CLK_DIV  clock cycles per digit slot (> BLANK)
//   CBITS    slot counter width, 2**CBITS > CLK_DIV
//   BLANK    dark cycles at the start of each slot (0 allowed)
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   seg_in      segment patterns, digit k = seg_in[7k+6:7k]
//   dig_en      per-digit enable, sampled only at slot boundaries
//   hold        freezes counter, index and outputs
//   segment     registered segment drive, active-high
//   digit_sel   registered one-hot digit drive, all-zero while dark
//   frame_tick  registered one-cycle pulse on wrap to the lowest enabled digit
// -----------------------------------------------------------------------------
module seven_seg_mux #(
    parameter int NDIG    = 4,
    parameter int CLK_DIV = 160000,
    parameter int CBITS   = 18,
    parameter int BLANK   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7*NDIG-1:0]   seg_in,
    input  logic [NDIG-1:0]     dig_en,
    input  logic                hold,
    output logic [6:0]          segment,
    output logic [NDIG-1:0]     digit_sel,
    output logic                frame_tick
);

    localparam int               IBITS   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CBITS-1:0] LAST_C  = CBITS'(CLK_DIV - 1);
    localparam logic [CBITS-1:0] BLANK_C = CBITS'(BLANK);
    localparam logic [IBITS-1:0] IDX_RST = IBITS'(NDIG - 1);

    logic [CBITS-1:0] cnt_q,  cnt_d;
    logic [IBITS-1:0] idx_q,  idx_d;
    logic             lit_q,  lit_d;   // current slot was entered with a digit enabled
    logic [6:0]       snap_q, snap_d;  // pattern captured for the current slot
    logic [6:0]       seg_q,  seg_d;
    logic [NDIG-1:0]  sel_q,  sel_d;
    logic             tick_q, tick_d;

    // Next-index search: lowest enabled index above idx_q, and lowest overall.
    logic             hi_found;
    logic [IBITS-1:0] hi_idx;
    logic [IBITS-1:0] lo_idx;

    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        // Scanning downwards leaves the smallest qualifying index in place.
        for (int i = NDIG - 1; i >= 0; i--) begin
            if (dig_en[i]) begin
                lo_idx = IBITS'(i);
                if (i > int'(idx_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = IBITS'(i);
                end
            end
        end
    end

    // Pattern of the digit that owns the slot after this edge.
    logic [6:0] cur_pat;

    always_comb begin
        cur_pat = seg_in[int'(idx_d) * 7 +: 7];
    end

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can
        // leave one unassigned and infer a latch.
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        lit_d  = lit_q;
        snap_d = snap_q;
        seg_d  = seg_q;
        sel_d  = sel_q;
        tick_d = 1'b0;

        if (!hold) begin
            if (cnt_q == LAST_C) begin
                // Advance edge: pick the next digit, or go dark if none enabled.
                cnt_d = '0;
                lit_d = |dig_en;
                if (|dig_en) begin
                    idx_d  = hi_found ? hi_idx : lo_idx;
                    tick_d = !hi_found;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end

            // Capture at the first lit cycle so later seg_in edits wait a slot.
            if (cnt_d == BLANK_C) begin
                snap_d = cur_pat;
            end

            if (lit_d && (cnt_d >= BLANK_C)) begin
                sel_d = NDIG'(1) << idx_d;
                seg_d = snap_d;
            end else begin
                sel_d = '0;
                seg_d = '0;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: every register has a reset value; the counter starts at its
            // last count so the first unheld edge is an advance edge.
            cnt_q  <= LAST_C;
            idx_q  <= IDX_RST;
            lit_q  <= 1'b0;
            snap_q <= '0;
            seg_q  <= '0;
            sel_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            lit_q  <= lit_d;
            snap_q <= snap_d;
            seg_q  <= seg_d;
            sel_q  <= sel_d;
            tick_q <= tick_d;
        end
    end

    assign segment    = seg_q;
    assign digit_sel  = sel_q;
    assign frame_tick = tick_q;

endmodule

// File: doc/seven_seg_mux.md
Name: seven_seg_mux

Overview:
Parametrised time-multiplexed driver for an NDIG-digit common-segment seven-segment display. It is the successor to the fixed two-digit, 14-bit refresh block.
- Rotates through only the enabled digits, one slot of CLK_DIV cycles each.
- Inserts an anti-ghosting blank at the start of every slot.
- Supports freeze (hold) and emits a per-frame tick.
- Sits between the display-data registers and the board pins.

Parameters:
NDIG, 4, number of digits (2..8)
CLK_DIV, 160000, clock cycles per digit slot (> BLANK)
CBITS, 18, slot counter width; must satisfy 2^CBITS > CLK_DIV
BLANK, 16, cycles at the start of each slot with all outputs dark (0 allowed)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
seg_in  input  7*NDIG  segment patterns; digit k = seg_in[7k+6:7k]
dig_en  input  NDIG  per-digit enable; disabled digits are skipped
hold  input  1  freeze: counter, index and outputs keep their values
segment  output  7  registered segment drive, active-high
digit_sel  output  NDIG  registered one-hot digit drive, active-high; all-zero when dark
frame_tick  output  1  registered one-cycle pulse when selection wraps to the lowest enabled digit

Behaviour:
- Reset (async, immediate, no clock needed):
  - segment=0, digit_sel=0, frame_tick=0.
  - cnt=CLK_DIV-1, idx=NDIG-1, snapshot=0.
- Slot counter:
  - hold=1: every register keeps its value and frame_tick is forced to 0; hold only extends the current slot.
  - hold=0: if cnt==CLK_DIV-1, cnt<=0 (advance edge), else cnt<=cnt+1.
- Advance edge, next-index rule:
  - idx_next = smallest enabled index greater than idx.
  - If none exists, idx_next = smallest enabled index overall, and frame_tick<=1 for exactly that cycle.
  - If dig_en==0 at the advance edge: idx unchanged, frame_tick=0, the slot is dark.
  - With a single enabled digit, frame_tick pulses every slot.
  - The first advance edge after reset release (first unheld edge) selects the lowest enabled digit and pulses frame_tick.
- Dark/lit per slot:
  - Cycles with cnt_next<BLANK are dark: digit_sel=0, segment=0.
  - The edge where cnt_next==BLANK samples seg_in slice idx into snapshot. With BLANK=0 this is the advance edge.
  - Cycles with cnt_next>=BLANK: digit_sel=onehot(idx), segment=snapshot.
  - A slot entered with dig_en==0 stays dark for its full length.
- Data stability:
  - seg_in changes after the snapshot edge are not visible until the next slot.
  - dig_en changes take effect only at the next advance edge. A digit disabled mid-slot finishes its slot.
- Glitch rule: digit_sel never has more than one bit set. Digit changes always pass through a dark cycle when BLANK>0.
- Frame period = CLK_DIV × (number of enabled digits), with no hold.
- Reset mid-slot discards the slot. Behaviour after release is identical to power-up.

Test Plan:
(Bench parameters: NDIG=4, CLK_DIV=8, BLANK=2; seg_in digits 3..0 = 7'h4F,7'h5B,7'h06,7'h3F.)
1. Reset, release with dig_en=4'b1111.
   -> First edge: frame_tick=1.
   -> digit_sel=0 for 2 cycles, then 4'b0001 with segment=7'h3F for 6 cycles.
   -> Then 4'b0010/7'h06, 4'b0100/7'h5B, 4'b1000/7'h4F.
   -> frame_tick repeats every 32 cycles.
2. dig_en=4'b1010.
   -> Order digit1(7'h06), digit3(7'h4F), digit1...
   -> frame_tick every 16 cycles; digits 0 and 2 never selected.
3. dig_en=0 mid-slot.
   -> Current slot completes; from the next advance, outputs stay 0 and no frame_tick.
   -> Set dig_en=4'b0100: next advance lights digit2 (7'h5B) after blanking; frame_tick every 8 cycles.
4. hold=1 for 5 cycles during the lit part of the digit1 slot.
   -> segment, digit_sel, cnt frozen; frame_tick 0.
   -> Slot lasts 13 cycles total; order unchanged.
5. Assert rst between clock edges while digit2 is lit.
   -> segment=0, digit_sel=0 immediately, with no edge needed.
   -> After release, scenario 1 sequence restarts from digit0.
6. Change digit0 pattern to 7'h7F at cnt=4 of a digit0 slot.
   -> segment stays 7'h3F until the slot ends.
   -> The next digit0 slot shows 7'h7F.
